// File: rtl/adder_arbiter_if.sv
// Requester-side bundle of the shared adder arbiter: per-requester request
// levels and operand slices in, one-hot grant/completion pulses and the sum out.
interface adder_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       sum_out;
    logic                   busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, sum_out, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, sum_out, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one Kogge-Stone prefix adder between up to four
// requesters; operands are registered before the adder, the sum after it.
module prefix_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);
    // Only carries into bits 1..WIDTH-1 are needed; the carry-out is dropped.
    localparam int CW     = WIDTH - 1;
    localparam int LEVELS = $clog2(CW);

    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] carry;

    assign p_bit    = a_i ^ b_i;
    assign carry[0] = 1'b0;

    // A node keeps its group propagate only while its span has not yet reached
    // bit 0; once it has, the group generate alone is the carry.
    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
            for (gj = 0; gj < CW; gj++) begin : g_node
                logic g;
                if (gi == 0) begin : g_leaf
                    assign g = a_i[gj] & b_i[gj];
                end else if (gj < (1 << (gi - 1))) begin : g_pass
                    assign g = g_lvl[gi-1].g_node[gj].g;
                end else begin : g_comb
                    assign g = g_lvl[gi-1].g_node[gj].g
                             | (g_lvl[gi-1].g_node[gj].g_has_p.p
                                & g_lvl[gi-1].g_node[gj-(1 << (gi - 1))].g);
                end
                if (gj >= (1 << gi)) begin : g_has_p
                    logic p;
                    if (gi == 0) begin : g_p_leaf
                        assign p = p_bit[gj];
                    end else begin : g_p_comb
                        assign p = g_lvl[gi-1].g_node[gj].g_has_p.p
                                 & g_lvl[gi-1].g_node[gj-(1 << (gi - 1))].g_has_p.p;
                    end
                end
            end
        end
        for (gi = 0; gi < CW; gi++) begin : g_carry
            assign carry[gi+1] = g_lvl[LEVELS].g_node[gi].g;
        end
    endgenerate

    assign sum_o = p_bit ^ carry;
endmodule

module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;

    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [WIDTH-1:0] adder_sum;

    prefix_adder #(.WIDTH(WIDTH)) u_adder (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (adder_sum)
    );

    // Scan from the highest offset down so the last hit is the one nearest ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(ptr_q) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        gnt_d   = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_a_d  = bus.a_in[win_idx*WIDTH +: WIDTH];
                    op_b_d  = bus.b_in[win_idx*WIDTH +: WIDTH];
                    owner_d = win_idx;
                    gnt_d   = ONE_HOT << win_idx;
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sum_d   = adder_sum;
                done_d  = ONE_HOT << owner_q;
                busy_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.sum_out = sum_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a transaction-scheduling reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_adder_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    adder_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
        return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    endfunction

    // Reference model: expected outputs per cycle slot, filled when a request is accepted.
    logic [N-1:0] e_gnt  [8];
    logic [N-1:0] e_done [8];
    logic         e_busy [8];
    logic         e_upd  [8];
    logic [W-1:0] e_val  [8];
    logic [W-1:0] m_sum;
    int           m_ptr;
    int unsigned  next_sample;

    always @(posedge clk or negedge rst_n) begin
        int s0, s1, w;
        if (!rst_n) begin
            cyc = 0;
            m_ptr = 0;
            next_sample = 0;
            m_sum = '0;
            for (int s = 0; s < 8; s++) begin
                e_gnt[s] = '0; e_done[s] = '0; e_busy[s] = 1'b0; e_upd[s] = 1'b0; e_val[s] = '0;
            end
        end else begin
            cyc++;
            s0 = int'(cyc % 8);
            s1 = int'((cyc + 1) % 8);
            e_gnt[s1] = '0; e_done[s1] = '0; e_busy[s1] = 1'b0; e_upd[s1] = 1'b0;
            if (cyc >= next_sample && bus.req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                e_gnt[s0]  = N'(1) << w;
                e_busy[s0] = 1'b1;
                e_done[s1] = N'(1) << w;
                e_busy[s1] = 1'b1;
                e_upd[s1]  = 1'b1;
                e_val[s1]  = W'((int'(bus.a_in[w*W +: W]) + int'(bus.b_in[w*W +: W])) % 256);
                m_ptr = (w + 1) % N;
                next_sample = cyc + 3;
            end
            if (e_upd[s0]) m_sum = e_val[s0];
        end
    end

    always @(negedge clk) begin
        int s;
        s = int'(cyc % 8);
        chk("model_gnt", bus.gnt, e_gnt[s]);
        chk("model_done", bus.done, e_done[s]);
        chk("model_sum", bus.sum_out, m_sum);
        chk("model_busy", bus.busy, e_busy[s]);
        if (bus.done != '0)
            $display("txn cyc=%0d done=%b sum=%0d", cyc, bus.done, bus.sum_out);
    end

    task automatic wait_sig(input bit want_done, output logic [3:0] seen, output int lat);
        seen = '0;
        lat = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seen = want_done ? bus.done : bus.gnt;
            if (seen != '0) begin
                lat = i;
                return;
            end
        end
        lat = 16;
        n_checks++;
        n_fail++;
        $display("FAIL wait_%s: got no pulse within 16 cycles, required one", want_done ? "done" : "gnt");
    endtask

    task automatic op(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] exp_g, input int exp_sum, input logic [3:0] r_after,
                      input string name, output int glat);
        logic [3:0] seen;
        int dlat;
        bus.req = r;
        bus.a_in = a;
        bus.b_in = b;
        wait_sig(1'b0, seen, glat);
        chk({name, "_gnt"}, seen, exp_g);
        bus.req = r_after;
        wait_sig(1'b1, seen, dlat);
        chk({name, "_done"}, seen, exp_g);
        chk({name, "_done_lat"}, dlat, 0);
        chk({name, "_sum"}, bus.sum_out, exp_sum);
    endtask

    initial begin
        int lat;
        logic [31:0] va, vb;
        bus.req = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_sum", bus.sum_out, 0);
        chk("idle_done", bus.done, 0);

        op(4'b0001, pk(0, 0, 0, 0), pk(65, 0, 0, 0), 4'b0001, 65, 4'b0000, "single0", lat);
        op(4'b0100, pk(0, 0, 100, 0), pk(0, 0, 24, 0), 4'b0100, 124, 4'b0000, "seq2a", lat);
        op(4'b0100, pk(0, 0, 85, 0), pk(0, 0, 170, 0), 4'b0100, 255, 4'b0000, "seq2b", lat);
        op(4'b0001, pk(200, 0, 0, 0), pk(100, 0, 0, 0), 4'b0001, 44, 4'b0000, "wrap_a", lat);
        op(4'b0001, pk(255, 0, 0, 0), pk(1, 0, 0, 0), 4'b0001, 0, 4'b0000, "wrap_b", lat);

        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        va = pk(10, 20, 30, 40);
        vb = pk(1, 2, 3, 4);
        op(4'b1111, va, vb, 4'b0001, 11, 4'b1111, "all_r0", lat);
        op(4'b1111, va, vb, 4'b0010, 22, 4'b1111, "all_r1", lat);
        op(4'b1111, va, vb, 4'b0100, 33, 4'b1111, "all_r2", lat);
        op(4'b1111, va, vb, 4'b1000, 44, 4'b1111, "all_r3", lat);
        op(4'b1111, va, vb, 4'b0001, 11, 4'b0000, "all_wrap", lat);

        op(4'b0010, pk(0, 7, 0, 0), pk(0, 8, 0, 0), 4'b0010, 15, 4'b0000, "fair_r1", lat);
        op(4'b0011, pk(50, 60, 0, 0), pk(5, 6, 0, 0), 4'b0001, 55, 4'b0010, "fair_r0", lat);
        op(4'b0010, pk(50, 60, 0, 0), pk(5, 6, 0, 0), 4'b0010, 66, 4'b0000, "fair_r1b", lat);

        bus.req = 4'b0100;
        bus.a_in = pk(0, 0, 5, 0);
        bus.b_in = pk(0, 0, 6, 0);
        begin
            logic [3:0] seen;
            wait_sig(1'b0, seen, lat);
            chk("midrst_gnt", seen, 4'b0100);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_gnt_clr", bus.gnt, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_sum", bus.sum_out, 0);
        bus.req = '0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", bus.done, 0);
        end
        #2 rst_n = 1'b1;
        op(4'b1000, pk(0, 0, 0, 9), pk(0, 0, 0, 10), 4'b1000, 19, 4'b0000, "post_rst_r3", lat);
        chk("post_rst_gnt_lat", lat, 0);

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (bus.gnt[i]) begin
                        if ($urandom_range(1) == 0) bus.req[i] = 1'b0;
                        bus.a_in[i*W +: W] = W'($urandom);
                        bus.b_in[i*W +: W] = W'($urandom);
                    end
                end else begin
                    bus.a_in[i*W +: W] = W'($urandom);
                    bus.b_in[i*W +: W] = W'($urandom);
                    if ($urandom_range(3) == 0) bus.req[i] = 1'b1;
                end
            end
        end
        bus.req = '0;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
